// File: rtl/control_puerta.sv
// Door-cycle controller: paces open/hold/close travel from 1 Hz ticks,
// with motor timeouts, hold-open on request/obstruction and a sticky fault.
module control_puerta #(
  parameter int OPEN_SECS       = 10,
  parameter int MOTOR_MAX_TICKS = 4,
  parameter int CNT_W           = 8
) (
  input  logic             C_100Mhz,
  input  logic             restart_n,
  input  logic             C_1Hz,
  input  logic             abrir_req,
  input  logic             obstruccion,
  input  logic             sensor_abierta,
  input  logic             sensor_cerrada,
  output logic             startTimer,
  output logic             restart,
  output logic             motor_abrir,
  output logic             motor_cerrar,
  output logic             time_expired,
  output logic             puerta_lista,
  output logic             falla,
  output logic [CNT_W-1:0] segundos
);

  typedef enum logic [2:0] {
    CERRADA,
    ABRIENDO,
    ABIERTA,
    CERRANDO,
    FALLA
  } state_t;

  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MOTOR_MAX_TICKS);
  localparam logic [CNT_W-1:0] L_OPEN = CNT_W'(OPEN_SECS);

  state_t           r_state;
  logic [CNT_W-1:0] r_seg;
  logic             r_tick_q;

  state_t           w_nstate;
  logic [CNT_W-1:0] w_nseg;
  logic [CNT_W-1:0] w_inc;
  logic             w_tick;
  logic             w_restart;
  logic             w_texp;
  logic             w_lista;

  assign w_tick   = C_1Hz & ~r_tick_q;
  assign w_inc    = (&r_seg) ? r_seg : r_seg + CNT_W'(1);
  assign segundos = r_seg;

  // Next state, counter update and the one-cycle event pulses.
  always_comb begin
    w_nstate  = r_state;
    w_nseg    = r_seg;
    w_restart = 1'b0;
    w_texp    = 1'b0;
    w_lista   = 1'b0;
    if (r_state != FALLA && sensor_abierta && sensor_cerrada) begin
      w_nstate = FALLA;
    end else begin
      unique case (r_state)
        CERRADA: begin
          if (abrir_req) begin
            w_nstate  = ABRIENDO;
            w_restart = 1'b1;
            w_nseg    = '0;
          end
        end
        ABRIENDO: begin
          if (sensor_abierta) begin
            w_nstate  = ABIERTA;
            w_restart = 1'b1;
            w_nseg    = '0;
          end else if (w_tick) begin
            w_nseg = w_inc;
            if (w_inc == L_MAX) w_nstate = FALLA;
          end
        end
        ABIERTA: begin
          if (abrir_req || obstruccion) begin
            w_nseg = '0;
          end else if (w_tick) begin
            if (w_inc == L_OPEN) begin
              w_nstate  = CERRANDO;
              w_texp    = 1'b1;
              w_restart = 1'b1;
              w_nseg    = '0;
            end else begin
              w_nseg = w_inc;
            end
          end
        end
        CERRANDO: begin
          if (obstruccion || abrir_req) begin
            w_nstate  = ABRIENDO;
            w_restart = 1'b1;
            w_nseg    = '0;
          end else if (sensor_cerrada) begin
            w_nstate = CERRADA;
            w_lista  = 1'b1;
          end else if (w_tick) begin
            w_nseg = w_inc;
            if (w_inc == L_MAX) w_nstate = FALLA;
          end
        end
        FALLA: begin
          w_nstate = FALLA;
        end
        default: begin
          w_nstate = CERRADA;
        end
      endcase
    end
  end

  // State, counter, edge-detect and registered outputs.
  always_ff @(posedge C_100Mhz or negedge restart_n) begin
    if (!restart_n) begin
      r_state      <= CERRADA;
      r_seg        <= '0;
      r_tick_q     <= 1'b0;
      startTimer   <= 1'b0;
      restart      <= 1'b0;
      motor_abrir  <= 1'b0;
      motor_cerrar <= 1'b0;
      time_expired <= 1'b0;
      puerta_lista <= 1'b0;
      falla        <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_seg        <= w_nseg;
      r_tick_q     <= C_1Hz;
      startTimer   <= (w_nstate == ABRIENDO) ||
                      (w_nstate == ABIERTA)  ||
                      (w_nstate == CERRANDO);
      restart      <= w_restart;
      motor_abrir  <= (w_nstate == ABRIENDO);
      motor_cerrar <= (w_nstate == CERRANDO);
      time_expired <= w_texp;
      puerta_lista <= w_lista;
      falla        <= (w_nstate == FALLA);
    end
  end

endmodule

// File: tb/tb_control_puerta.sv
// Directed bench for control_puerta: door cycle, hold-open, reopen,
// motor timeout, coincident events, edge detect and async reset.
module tb_control_puerta;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c1hz = 1'b0;
  logic       abrir = 1'b0;
  logic       obs = 1'b0;
  logic       sa = 1'b0;
  logic       sc = 1'b0;
  logic       start_t;
  logic       rstp;
  logic       m_ab;
  logic       m_ce;
  logic       texp;
  logic       lista;
  logic       fal;
  logic [7:0] seg;

  int n_chk = 0;
  int n_pass = 0;
  int n_rst = 0;
  int n_texp = 0;
  int n_lista = 0;
  int n_both = 0;
  int snap;

  control_puerta dut (
    .C_100Mhz      (clk),
    .restart_n     (rst_n),
    .C_1Hz         (c1hz),
    .abrir_req     (abrir),
    .obstruccion   (obs),
    .sensor_abierta(sa),
    .sensor_cerrada(sc),
    .startTimer    (start_t),
    .restart       (rstp),
    .motor_abrir   (m_ab),
    .motor_cerrar  (m_ce),
    .time_expired  (texp),
    .puerta_lista  (lista),
    .falla         (fal),
    .segundos      (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (rstp) n_rst++;
    if (texp) n_texp++;
    if (lista) n_lista++;
    if (m_ab && m_ce) n_both++;
  end

  task automatic chk(input string tag, input int obs_v, input int exp_v);
    n_chk++;
    if (obs_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs_v, exp_v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk) c1hz = 1'b1;
      @(negedge clk) c1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic p_abrir();
    @(negedge clk) abrir = 1'b1;
    @(negedge clk) abrir = 1'b0;
  endtask

  task automatic p_obs();
    @(negedge clk) obs = 1'b1;
    @(negedge clk) obs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    chk("rst_start", start_t, 0);
    chk("rst_motors", m_ab | m_ce, 0);
    chk("rst_falla", fal, 0);
    chk("rst_seg", seg, 0);
    rst_n = 1'b1;
    cyc(2);

    // normal cycle
    p_abrir();
    chk("open_motor", m_ab, 1);
    chk("open_timer", start_t, 1);
    chk("open_restart", n_rst, 1);
    tick(2);
    chk("open_seg2", seg, 2);
    @(negedge clk) sa = 1'b1;
    @(negedge clk);
    chk("ab_motor", m_ab, 0);
    chk("ab_seg", seg, 0);
    chk("ab_restart", n_rst, 2);
    chk("ab_timer", start_t, 1);
    tick(9);
    chk("ab_seg9", seg, 9);
    chk("ab_noexp", n_texp, 0);
    tick(1);
    chk("exp_pulse", n_texp, 1);
    chk("exp_close", m_ce, 1);
    chk("exp_restart", n_rst, 3);
    chk("exp_seg", seg, 0);
    sa = 1'b0;
    @(negedge clk) sc = 1'b1;
    @(negedge clk) sc = 1'b0;
    cyc(2);
    chk("lista_pulse", n_lista, 1);
    chk("closed_motors", m_ab | m_ce, 0);
    chk("closed_timer", start_t, 0);

    // hold-open extension
    p_abrir();
    @(negedge clk) sa = 1'b1;
    @(negedge clk);
    tick(7);
    chk("hold_seg7", seg, 7);
    snap = n_rst;
    p_obs();
    chk("hold_clear", seg, 0);
    chk("hold_norestart", n_rst, snap);
    tick(9);
    chk("hold_seg9", seg, 9);
    chk("hold_noexp", n_texp, 1);
    tick(1);
    chk("hold_exp17", n_texp, 2);
    chk("hold_close", m_ce, 1);

    // reopen while closing
    sa = 1'b0;
    tick(1);
    chk("close_seg1", seg, 1);
    snap = n_rst;
    p_obs();
    chk("reopen_ab", m_ab, 1);
    chk("reopen_ce", m_ce, 0);
    chk("reopen_rst", n_rst, snap + 1);
    chk("reopen_seg", seg, 0);

    // motor timeout
    tick(3);
    chk("to_seg3", seg, 3);
    chk("to_nofault", fal, 0);
    tick(1);
    chk("to_falla", fal, 1);
    chk("to_motors", m_ab | m_ce, 0);
    chk("to_timer", start_t, 0);
    p_abrir();
    cyc(1);
    chk("to_sticky", fal, 1);
    chk("to_ignore", m_ab, 0);
    @(negedge clk) rst_n = 1'b0;
    #1 chk("to_clear", fal, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // switch wins over timeout tick
    p_abrir();
    tick(3);
    @(negedge clk) begin
      c1hz = 1'b1;
      sa = 1'b1;
    end
    @(negedge clk) c1hz = 1'b0;
    @(negedge clk);
    chk("sim_nofault", fal, 0);
    chk("sim_open", start_t & ~m_ab, 1);
    chk("sim_seg", seg, 0);
    tick(9);
    snap = n_texp;
    @(negedge clk) begin
      c1hz = 1'b1;
      obs = 1'b1;
    end
    @(negedge clk) begin
      c1hz = 1'b0;
      obs = 1'b0;
    end
    @(negedge clk);
    chk("sim_clr_seg", seg, 0);
    chk("sim_clr_noexp", n_texp, snap);
    chk("sim_clr_noclose", m_ce, 0);
    sa = 1'b0;

    // both switches while closed
    do_reset();
    @(negedge clk) begin
      sa = 1'b1;
      sc = 1'b1;
    end
    @(negedge clk) begin
      sa = 1'b0;
      sc = 1'b0;
    end
    chk("both_falla", fal, 1);
    do_reset();

    // long C_1Hz high counts one tick
    p_abrir();
    @(negedge clk) c1hz = 1'b1;
    cyc(2000);
    chk("edge_seg1", seg, 1);
    chk("edge_motor", m_ab, 1);
    c1hz = 1'b0;
    cyc(2);

    // async reset mid-travel
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_motor", m_ab, 0);
    chk("async_timer", start_t, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    chk("interlock", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
